multiword_add_ctrl: RTL and testbench

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

---
 rtl/multiword_add_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multiword_add_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// Nibble-serial adder: one 4-bit ripple_adder reused over NIBBLES clocks, LSB nibble first.
// Optional SUBTRACT_EN adds a 'sub' port selecting a - b (two's complement via ~b and carry-in 1).

module ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module multiword_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef SUBTRACT_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;
`ifdef SUBTRACT_EN
    logic            sub_q, sub_d;
`endif

    logic [3:0]      nib_a, nib_b, add_sum;
    logic            add_cin, add_cout;

    ripple_adder u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Operand nibble select; idx 0 takes the registered carry-in, later nibbles the carry chain.
    always_comb begin
        logic [3:0] raw_b;
        nib_a = '0;
        raw_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[i*4 +: 4];
                raw_b = b_q[i*4 +: 4];
            end
        end
`ifdef SUBTRACT_EN
        nib_b   = sub_q ? ~raw_b : raw_b;
        add_cin = (idx_q == '0) ? (sub_q | cin_q) : carry_q;
`else
        nib_b   = raw_b;
        add_cin = (idx_q == '0) ? cin_q : carry_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
`ifdef SUBTRACT_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    cin_d   = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    carry_d = 1'b0;
`ifdef SUBTRACT_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) sum_d[i*4 +: 4] = add_sum;
                end
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = add_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
`ifdef SUBTRACT_EN
            sub_q   <= sub_d;
`endif
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl at NIBBLES=4; subtract vectors run only with SUBTRACT_EN.

module tb_multiword_add_ctrl;
    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0]   a, b, sum;
    logic          sub_in;

    int unsigned   n_total = 0;
    int unsigned   n_pass  = 0;

    always #5 clk = ~clk;

    multiword_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUBTRACT_EN
        .sub       (sub_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vsub;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure latency/busy cycles, check result, then consume it.
    task automatic run_op(input vec_t v);
        int unsigned lat, busy_cnt;
        check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
        a = v.va; b = v.vb; cin = v.vcin; sub_in = v.vsub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check("latency", lat, N);
        check("busy_cycles", busy_cnt, N);
        check("sum", {16'b0, sum}, {16'b0, v.exp_sum});
        check("cout", {31'b0, cout}, {31'b0, v.exp_cout});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", {31'b0, out_valid}, 32'd0);
    endtask

    vec_t vecs[7];
    vec_t hold_v, rst_v, post_v;
    logic [15:0] held_sum;
    logic        rose;

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_in = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Result must hold in DONE while producer waves new operands.
        hold_v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0};
        a = hold_v.va; b = hold_v.vb; cin = 1'b0; sub_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        check("hold_reached_done", {31'b0, out_valid}, 32'd1);
        held_sum = sum;
        check("hold_sum_initial", {16'b0, held_sum}, 32'h3333);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 16'h1000 + 16'(k); b = 16'h0F00 - 16'(k); cin = 1'(k);
            tick();
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_sum", {16'b0, sum}, 32'h3333);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_busy", {31'b0, busy}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release", {31'b0, out_valid}, 32'd0);
        check("hold_idle_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("hold_no_second_op", {31'b0, busy}, 32'd0);

        // Reset after two RUN cycles discards the operation.
        rst_v = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0};
        a = rst_v.va; b = rst_v.vb; cin = rst_v.vcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        check("midrst_partial_sum", {16'b0, sum}, 32'h00FF);
        rst = 1'b1;
        tick();
        check("midrst_in_ready_during", {31'b0, in_ready}, 32'd0);
        check("midrst_sum", {16'b0, sum}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", {31'b0, in_ready}, 32'd1);
        rose = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rose = rose | out_valid;
            tick();
        end
        check("midrst_no_out_valid", {31'b0, rose}, 32'd0);
        post_v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0};
        run_op(post_v);

`ifdef SUBTRACT_EN
        run_op('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0});
        run_op('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
